sram_arb_2port: RTL and testbench

SRAM_ARB_2PORT -- requirements
Module: sram_arb_2port

---
 rtl/sram_arb_2port.sv | 139 +++++++++++++
 tb/tb_sram_arb_2port.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_2port.sv
// Two-port arbiter in front of a single-ported SRAM.
// One access is granted per enabled cycle. The command is registered toward the
// SRAM in the next cycle, and read data returns to the requesting port two
// cycles after the grant.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// When it is left undefined, port a has fixed priority.
module sram_arb_2port #(
  parameter int address_width = 14,
  parameter int data_width    = 32
) (
  input  logic                     sram_clock,
  input  logic                     sram_reset,
  input  logic                     sram_clock__enable,
  input  logic                     req_a,
  input  logic [address_width-1:0] address_a,
  input  logic [data_width-1:0]    write_data_a,
  input  logic [3:0]               write_enable_a,
  input  logic                     read_not_write_a,
  output logic                     ack_a,
  output logic                     rdata_valid_a,
  output logic [data_width-1:0]    rdata_a,
  input  logic                     req_b,
  input  logic [address_width-1:0] address_b,
  input  logic [data_width-1:0]    write_data_b,
  input  logic [3:0]               write_enable_b,
  input  logic                     read_not_write_b,
  output logic                     ack_b,
  output logic                     rdata_valid_b,
  output logic [data_width-1:0]    rdata_b,
  output logic                     select,
  output logic [address_width-1:0] address,
  output logic [data_width-1:0]    write_data,
  output logic [3:0]               write_enable,
  output logic                     read_not_write,
  input  logic [data_width-1:0]    data_out
);

  localparam logic [0:0] PORT_A = 1'b0;
  localparam logic [0:0] PORT_B = 1'b1;

  logic                     grant_a;
  logic                     grant_b;
  logic                     any_ack;
  logic [address_width-1:0] win_address;
  logic [data_width-1:0]    win_write_data;
  logic [3:0]               win_write_enable;
  logic                     win_read_not_write;
  logic                     rd1_valid;
  logic [0:0]               rd1_port;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [0:0] rr_ptr;

  // On contention the pointed-to port wins; a lone requester always wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_a = (rr_ptr == PORT_A);
      grant_b = (rr_ptr == PORT_B);
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  // The pointer moves to the port that did not just receive the grant.
  always_ff @(posedge sram_clock) begin
    if (sram_reset)  rr_ptr <= PORT_A;
    else if (ack_a)  rr_ptr <= PORT_B;
    else if (ack_b)  rr_ptr <= PORT_A;
  end
`else
  // Fixed priority: port a always wins contention.
  always_comb begin
    grant_a = req_a;
    grant_b = req_b & ~req_a;
  end
`endif

  assign ack_a   = grant_a & sram_clock__enable & ~sram_reset;
  assign ack_b   = grant_b & sram_clock__enable & ~sram_reset;
  assign any_ack = ack_a | ack_b;

  // Route the winning port's command fields toward the SRAM register.
  always_comb begin
    win_address        = address_a;
    win_write_data     = write_data_a;
    win_write_enable   = write_enable_a;
    win_read_not_write = read_not_write_a;
    if (ack_b) begin
      win_address        = address_b;
      win_write_data     = write_data_b;
      win_write_enable   = write_enable_b;
      win_read_not_write = read_not_write_b;
    end
  end

  // SRAM command register. Byte enables are masked on reads; idle cycles drop select and enables.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      select         <= 1'b0;
      address        <= '0;
      write_data     <= '0;
      write_enable   <= '0;
      read_not_write <= 1'b0;
    end else if (sram_clock__enable) begin
      select <= any_ack;
      if (any_ack) begin
        address        <= win_address;
        write_data     <= win_write_data;
        read_not_write <= win_read_not_write;
        write_enable   <= win_read_not_write ? 4'h0 : win_write_enable;
      end else begin
        write_enable <= '0;
      end
    end
  end

  // Read return pipeline: stage 1 tracks the read in flight, stage 2 captures SRAM data for its port.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      rd1_valid     <= 1'b0;
      rd1_port      <= PORT_A;
      rdata_valid_a <= 1'b0;
      rdata_valid_b <= 1'b0;
      rdata_a       <= '0;
      rdata_b       <= '0;
    end else if (sram_clock__enable) begin
      rd1_valid     <= any_ack & win_read_not_write;
      rd1_port      <= ack_b ? PORT_B : PORT_A;
      rdata_valid_a <= rd1_valid & (rd1_port == PORT_A);
      rdata_valid_b <= rd1_valid & (rd1_port == PORT_B);
      rdata_a       <= (rd1_valid && rd1_port == PORT_A) ? data_out : '0;
      rdata_b       <= (rd1_valid && rd1_port == PORT_B) ? data_out : '0;
    end
  end

endmodule

// File: tb/tb_sram_arb_2port.sv
// Randomized bench for sram_arb_2port.
// Directed scenarios come first, followed by random traffic. Expected behaviour
// comes from a transaction-level model indexed by the count of state-advancing
// clock edges.
module tb_sram_arb_2port;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          sram_clock = 1'b0;
  logic          sram_reset;
  logic          sram_clock__enable;
  logic          req_a, req_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] write_data_a, write_data_b;
  logic [3:0]    write_enable_a, write_enable_b;
  logic          read_not_write_a, read_not_write_b;
  logic          ack_a, ack_b, rdata_valid_a, rdata_valid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          select, read_not_write;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [3:0]    write_enable;
  logic [DW-1:0] data_out;

  sram_arb_2port #(.address_width(AW), .data_width(DW)) dut (
    .sram_clock(sram_clock), .sram_reset(sram_reset), .sram_clock__enable(sram_clock__enable),
    .req_a(req_a), .address_a(address_a), .write_data_a(write_data_a),
    .write_enable_a(write_enable_a), .read_not_write_a(read_not_write_a),
    .ack_a(ack_a), .rdata_valid_a(rdata_valid_a), .rdata_a(rdata_a),
    .req_b(req_b), .address_b(address_b), .write_data_b(write_data_b),
    .write_enable_b(write_enable_b), .read_not_write_b(read_not_write_b),
    .ack_b(ack_b), .rdata_valid_b(rdata_valid_b), .rdata_b(rdata_b),
    .select(select), .address(address), .write_data(write_data),
    .write_enable(write_enable), .read_not_write(read_not_write), .data_out(data_out)
  );

  always #5 sram_clock = ~sram_clock;

  // Behavioural SRAM: asynchronous read, byte-lane write on each rising edge while selected.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  assign data_out = sram_mem[address];
  always @(posedge sram_clock) begin
    if (select === 1'b1 && read_not_write === 1'b0)
      for (int i = 0; i < 4; i++)
        if (write_enable[i]) sram_mem[address][8*i +: 8] <= write_data[8*i +: 8];
  end

  typedef struct packed {
    logic          sel;
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [3:0]    we;
    logic          rnw;
  } cmd_t;
  typedef struct packed {
    logic          va;
    logic          vb;
    logic [DW-1:0] d;
  } ret_t;

  cmd_t          cmd_q [16];
  ret_t          ret_q [16];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int unsigned   ec = 0;
  logic          have_ec = 1'b0;
  logic          last_a, last_b;
  int            obs_a = 0, obs_b = 0;
  int            checks = 0, failures = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic          m_ptr_b = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic r, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [3:0] w, input logic rn);
    req_a = r; address_a = ad; write_data_a = d; write_enable_a = w; read_not_write_a = rn;
  endtask

  task automatic set_b(input logic r, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic [3:0] w, input logic rn);
    req_b = r; address_b = ad; write_data_b = d; write_enable_b = w; read_not_write_b = rn;
  endtask

  task automatic idle_all();
    set_a(1'b0, '0, '0, 4'h0, 1'b0);
    set_b(1'b0, '0, '0, 4'h0, 1'b0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 14'h3FFF;
    return 14'($urandom_range(0, 15));
  endfunction

  task automatic rand_a();
    set_a(1'($urandom_range(0, 3) != 0), rand_addr(), $urandom(),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_b();
    set_b(1'($urandom_range(0, 3) != 0), rand_addr(), $urandom(),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  // One clock cycle: apply the controls, check at the falling edge, advance the model, then return just after the rising edge.
  task automatic step(input logic en, input logic rst);
    logic ea, eb, pb;
    cmd_t c;
    ret_t r;
    sram_clock__enable = en;
    sram_reset = rst;
    @(negedge sram_clock);
    ea = 1'b0;
    eb = 1'b0;
    if (en && !rst) begin
      if (req_a && req_b) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ea = !m_ptr_b;
        eb = m_ptr_b;
`else
        ea = 1'b1;
`endif
      end else begin
        ea = req_a;
        eb = req_b;
      end
    end
    if (ack_a === 1'b1) obs_a++;
    if (ack_b === 1'b1) obs_b++;
    if (have_ec) begin
      c = cmd_q[ec % 16];
      r = ret_q[ec % 16];
      check("ack_a", ack_a, ea);
      check("ack_b", ack_b, eb);
      check("select", select, c.sel);
      check("write_enable", write_enable, c.we);
      if (c.full) begin
        check("address", address, c.addr);
        check("write_data", write_data, c.wd);
        check("read_not_write", read_not_write, c.rnw);
      end
      check("rdata_valid_a", rdata_valid_a, r.va);
      check("rdata_valid_b", rdata_valid_b, r.vb);
      check("rdata_a", rdata_a, r.va ? r.d : '0);
      check("rdata_b", rdata_b, r.vb ? r.d : '0);
    end
    if (rst) begin
      c = '0;
      c.full = 1'b1;
      cmd_q[(ec + 1) % 16] = c;
      ret_q[(ec + 1) % 16] = '0;
      ret_q[(ec + 2) % 16] = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      m_ptr_b = 1'b0;
`endif
      ec++;
      have_ec = 1'b1;
    end else if (en) begin
      c = '0;
      r = '0;
      if (ea || eb) begin
        pb = eb;
        c.sel  = 1'b1;
        c.full = 1'b1;
        c.addr = pb ? address_b : address_a;
        c.wd   = pb ? write_data_b : write_data_a;
        c.rnw  = pb ? read_not_write_b : read_not_write_a;
        c.we   = c.rnw ? 4'h0 : (pb ? write_enable_b : write_enable_a);
        if (c.rnw) begin
          r.va = !pb;
          r.vb = pb;
          r.d  = ref_mem[c.addr];
        end else begin
          for (int i = 0; i < 4; i++)
            if (c.we[i]) ref_mem[c.addr][8*i +: 8] = c.wd[8*i +: 8];
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        m_ptr_b = !pb;
`endif
      end
      cmd_q[(ec + 1) % 16] = c;
      ret_q[(ec + 2) % 16] = r;
      ec++;
    end
    last_a = ea;
    last_b = eb;
    @(posedge sram_clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, b0;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = $urandom();
      sram_mem[i] = v;
      ref_mem[i] = v;
    end
    idle_all();

    // Write 0xDEADBEEF, then read it back through port a.
    step(1'b1, 1'b1);
    set_a(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
    step(1'b1, 1'b0);
    set_a(1'b1, 14'h0010, 32'h0, 4'hF, 1'b1);
    step(1'b1, 1'b0);
    idle_all();
    step(1'b1, 1'b0);
    check("deadbeef_valid", rdata_valid_a, 1'b1);
    check("deadbeef_data", rdata_a, 32'hDEADBEEF);
    step(1'b1, 1'b0);

    // Partial byte-lane write at the top address.
    set_a(1'b1, 14'h3FFF, 32'hFFFFFFFF, 4'hF, 1'b0);
    step(1'b1, 1'b0);
    set_a(1'b1, 14'h3FFF, 32'h11223344, 4'h2, 1'b0);
    step(1'b1, 1'b0);
    check("lane1_we", write_enable, 4'h2);
    set_a(1'b1, 14'h3FFF, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    idle_all();
    step(1'b1, 1'b0);
    check("lane1_data", rdata_a, 32'hFFFF33FF);
    set_b(1'b1, 14'h0005, 32'hA5A5A5A5, 4'h0, 1'b0);
    step(1'b1, 1'b0);
    idle_all();
    step(1'b1, 1'b0);

    // Sustained contention from both ports for 8 cycles, starting after reset.
    step(1'b1, 1'b1);
    set_a(1'b1, 14'h0001, 32'h0, 4'h0, 1'b1);
    set_b(1'b1, 14'h0002, 32'h0, 4'h0, 1'b1);
    a0 = obs_a;
    b0 = obs_b;
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    check("contend_acks_a", 64'(obs_a - a0), 64'd4);
    check("contend_acks_b", 64'(obs_b - b0), 64'd4);
`else
    check("contend_acks_a", 64'(obs_a - a0), 64'd8);
    check("contend_acks_b", 64'(obs_b - b0), 64'd0);
`endif
    idle_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Back-to-back reads a:1, b:2, a:3.
    set_a(1'b1, 14'h0001, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    set_a(1'b0, '0, '0, 4'h0, 1'b0);
    set_b(1'b1, 14'h0002, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    set_b(1'b0, '0, '0, 4'h0, 1'b0);
    set_a(1'b1, 14'h0003, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    idle_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Clock enable held low for 3 cycles while a read is in flight.
    set_a(1'b1, 14'h0010, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    idle_all();
    set_b(1'b1, 14'h0004, 32'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("freeze_valid_a", rdata_valid_a, 1'b1);
    check("freeze_data_a", rdata_a, 32'hDEADBEEF);
    idle_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Reset asserted in the SRAM cycle of an accepted read.
    set_a(1'b1, 14'h0010, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    idle_all();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    set_a(1'b1, 14'h0006, 32'h0, 4'h0, 1'b1);
    set_b(1'b1, 14'h0007, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    check("post_reset_winner_a", last_a, 1'b1);
    idle_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Random traffic with occasional enable drops and resets.
    rand_a();
    rand_b();
    for (int n = 0; n < 800; n++) begin
      logic ren, rrst;
      ren  = 1'($urandom_range(0, 7) != 0);
      rrst = 1'($urandom_range(0, 63) == 0);
      step(ren, rrst);
      if (last_a || !req_a) rand_a();
      if (last_b || !req_b) rand_b();
    end
    idle_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
